// File: rtl/alarm_pkg.sv
// Shared type definitions for the input conditioner and the downstream alarm FSM.
// Both stages import this package so that they use one set of state encodings.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } deb_state_t;

    typedef enum logic [1:0] {
        ALARM_OFF,
        ALARM_ARMED,
        ALARM_TRIGGERED,
        ALARM_SOUNDING
    } alarm_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: a 2-FF synchronizer feeding a counter FSM that produces a
// registered level and a single-cycle pulse on each accepted rise.
//
// state       | meaning
// IDLE_LOW    | accepted level 0, input quiet
// WAIT_HIGH   | input went high, counting stable-high cycles
// STABLE_HIGH | accepted level 1, input quiet
// WAIT_LOW    | input went low, counting stable-low cycles
module debounce_channel
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             s;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
            state     <= IDLE_LOW;
            cnt       <= '0;
            level     <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_meta <= raw;
            s         <= sync_meta;
            pulse     <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HIGH;
                        level <= 1'b1;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    // A return to high here is a release glitch: level stays, no pulse.
                    if (s) begin
                        state <= STABLE_HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw H and B board inputs into clean levels and one-cycle rise
// pulses for the alarm FSM; the two channels are fully independent.
module input_conditioner
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_h,
    input  logic raw_b,
    output logic h_level,
    output logic b_level,
    output logic h_pulse,
    output logic b_pulse
);

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_h (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_h),
        .level(h_level),
        .pulse(h_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_b),
        .level(b_level),
        .pulse(b_pulse)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Per-cycle scoreboard against a run-length model, plus per-segment table checks.
module tb_input_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_h = 1'b0;
    logic raw_b = 1'b0;
    logic h_level, b_level, h_pulse, b_pulse;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_h  (raw_h),
        .raw_b  (raw_b),
        .h_level(h_level),
        .b_level(b_level),
        .h_pulse(h_pulse),
        .b_pulse(b_pulse)
    );

    typedef struct packed {
        logic hl;
        logic bl;
        logic hp;
        logic bp;
    } out_t;

    typedef struct {
        logic rst;
        logic h;
        logic b;
        int   cycles;
        int   hp;
        int   bp;
        int   fh;
        int   fb;
        logic hl;
        logic bl;
    } seg_t;

    out_t exp_q[$];
    seg_t tbl[$];

    int errors = 0;
    int checks = 0;

    // Model: the accepted level flips once the synchronized input has differed
    // from it on D+1 consecutive edges; any agreeing edge restarts the run.
    logic m_s1[2];
    logic m_s[2];
    logic m_lvl[2];
    logic m_pls[2];
    int   m_run[2];

    int seg_hp, seg_bp, first_h, first_b, idx;

    task automatic model_edge(input logic r, input logic rh, input logic rb);
        logic rw[2];
        rw[0] = rh;
        rw[1] = rb;
        for (int ch = 0; ch < 2; ch++) begin
            if (r) begin
                m_s1[ch] = 1'b0; m_s[ch] = 1'b0; m_lvl[ch] = 1'b0;
                m_pls[ch] = 1'b0; m_run[ch] = 0;
            end else begin
                m_pls[ch] = 1'b0;
                if (m_s[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D + 1) begin
                        m_lvl[ch] = ~m_lvl[ch];
                        m_run[ch] = 0;
                        m_pls[ch] = m_lvl[ch];
                    end
                end else begin
                    m_run[ch] = 0;
                end
                m_s[ch]  = m_s1[ch];
                m_s1[ch] = rw[ch];
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic b);
        out_t e;
        out_t got;
        @(negedge clk);
        rst   = r;
        raw_h = h;
        raw_b = b;
        model_edge(r, h, b);
        exp_q.push_back({m_lvl[0], m_lvl[1], m_pls[0], m_pls[1]});
        @(posedge clk);
        #1;
        idx++;
        got = {h_level, b_level, h_pulse, b_pulse};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL cycle t=%0t: got hl/bl/hp/bp=%b, expected %b", $time, got, e);
            end
        end
        if (h_pulse === 1'b1) begin
            seg_hp++;
            if (first_h == 0) first_h = idx;
        end
        if (b_pulse === 1'b1) begin
            seg_bp++;
            if (first_b == 0) first_b = idx;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 1'b0; m_s[ch] = 1'b0; m_lvl[ch] = 1'b0;
            m_pls[ch] = 1'b0; m_run[ch] = 0;
        end

        //            rst h  b  cyc hp bp fh fb hl bl
        tbl.push_back('{1, 1, 1, 3,  0, 0, 0, 0, 0, 0});  // reset with both held high
        tbl.push_back('{0, 1, 1, 10, 1, 1, 7, 7, 1, 1});  // debounced after release
        tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0, 0});  // simultaneous release
        tbl.push_back('{0, 1, 0, 10, 1, 0, 7, 0, 1, 0});  // clean H press
        tbl.push_back('{0, 0, 0, 2,  0, 0, 0, 0, 1, 0});  // release glitch
        tbl.push_back('{0, 1, 0, 10, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1,  0, 0, 0, 0, 0, 0});  // B bounce 1,0,1,0
        tbl.push_back('{0, 0, 0, 1,  0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 1,  0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 20, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 5,  0, 0, 0, 0, 0, 0});  // reset mid-count
        tbl.push_back('{1, 1, 0, 1,  0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 10, 1, 0, 7, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 4,  0, 0, 0, 0, 0, 0});  // D-cycle press: rejected
        tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 5,  0, 0, 0, 0, 0, 0});  // D+1-cycle press: accepted
        tbl.push_back('{0, 0, 0, 12, 1, 0, 2, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 7,  1, 1, 7, 7, 1, 1});  // reset right during the pulse
        tbl.push_back('{1, 1, 1, 1,  0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            seg_hp = 0; seg_bp = 0; first_h = 0; first_b = 0; idx = 0;
            for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].rst, tbl[i].h, tbl[i].b);
            check($sformatf("seg%0d h_pulse_count", i), seg_hp, tbl[i].hp);
            check($sformatf("seg%0d b_pulse_count", i), seg_bp, tbl[i].bp);
            check($sformatf("seg%0d h_pulse_edge", i), first_h, tbl[i].fh);
            check($sformatf("seg%0d b_pulse_edge", i), first_b, tbl[i].fb);
            check($sformatf("seg%0d h_level_end", i), int'(h_level), int'(tbl[i].hl));
            check($sformatf("seg%0d b_level_end", i), int'(b_level), int'(tbl[i].bl));
        end

        // Exact press latency: nothing after edge 6, level and pulse after edge 7,
        // pulse gone after edge 8 while the level holds.
        for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 1'b0);
        check("latency h_level_edge6", int'(h_level), 0);
        check("latency h_pulse_edge6", int'(h_pulse), 0);
        step(1'b0, 1'b1, 1'b0);
        check("latency h_level_edge7", int'(h_level), 1);
        check("latency h_pulse_edge7", int'(h_pulse), 1);
        step(1'b0, 1'b1, 1'b0);
        check("latency h_pulse_edge8", int'(h_pulse), 0);
        check("latency h_level_edge8", int'(h_level), 1);

        // Exact release latency, no pulse on the way down.
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b0);
        check("release h_level_edge6", int'(h_level), 1);
        step(1'b0, 1'b0, 1'b0);
        check("release h_level_edge7", int'(h_level), 0);
        check("release h_pulse_edge7", int'(h_pulse), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Two-channel button/switch conditioner placed directly upstream of the alarm state machine on the Basys board. It synchronizes the raw `H` and `B` board inputs into `clk`, debounces each one with a per-channel counter FSM, and produces a clean level plus a single-cycle rising-edge pulse per channel. `h_pulse` and `b_pulse` drive the alarm FSM's `H` and `B` inputs directly. Each physical press therefore advances the alarm FSM at most once.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive stable synchronized cycles required to accept a new level; legal range ≥ 2.
- `clk`  input  1  system clock; one clock for the whole block.
- `rst`  input  1  reset, synchronous, active-high.
- `raw_h`  input  1  asynchronous, bouncy H input from the board.
- `raw_b`  input  1  asynchronous, bouncy B input from the board.
- `h_level`  output  1  debounced level of H.
- `b_level`  output  1  debounced level of B.
- `h_pulse`  output  1  one-cycle pulse on each accepted H rise.
- `b_pulse`  output  1  one-cycle pulse on each accepted B rise.

## Operation
- Each channel works independently: a 2-FF synchronizer produces `s`, and `s` feeds a 4-state FSM with counter `cnt`.
- **`IDLE_LOW`** (level 0): if `s`=1, go to `WAIT_HIGH` and clear `cnt` to 0. Otherwise stay.
- **`WAIT_HIGH`**:
  - If `s`=0, return to `IDLE_LOW`; this is a bounce and is discarded.
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1, go to `STABLE_HIGH`.
  - Else increment `cnt`.
- **`STABLE_HIGH`** (level 1): if `s`=0, go to `WAIT_LOW` and clear `cnt`.
- **`WAIT_LOW`**:
  - If `s`=1, return to `STABLE_HIGH`.
  - Else if `cnt`==`DEBOUNCE_CYCLES`-1, go to `IDLE_LOW`.
  - Else increment `cnt`.
- `*_level` is 1 exactly in states `STABLE_HIGH` and `WAIT_LOW`. It is registered, with no combinational path from raw inputs.
- `*_pulse` is 1 for exactly one cycle: the first cycle the FSM is in `STABLE_HIGH` after leaving `WAIT_HIGH`. Re-entering `STABLE_HIGH` from `WAIT_LOW` generates no pulse. There is no pulse on release.
- `cnt` width is `$clog2(DEBOUNCE_CYCLES)`. It never wraps; the terminal compare precedes any increment.
- Simultaneous H and B presses are legal and each produces its own pulse, possibly in the same cycle. Resolving priority is the consumer's job.

## Timing
- Reset values:
  - all synchronizer flops 0
  - both FSMs in `IDLE_LOW`
  - `cnt` = 0
  - `h_level`, `b_level`, `h_pulse`, `b_pulse` all 0
- If `rst` is asserted mid-debounce or mid-pulse, all outputs are 0 on the next edge and any partial count is discarded.
- If a raw input is held high through reset release, it is debounced normally from `IDLE_LOW` and produces one pulse. Nothing is suppressed.
- Press latency:
  - Counting the first edge that samples `raw`=1 as edge 1, `*_level` and `*_pulse` rise after edge `DEBOUNCE_CYCLES`+3.
  - Breakdown: 2 synchronizer edges, 1 edge to enter `WAIT_HIGH`, then `DEBOUNCE_CYCLES` edges to accept.
- Release latency: symmetric, `*_level` falls after edge `DEBOUNCE_CYCLES`+3.
- Minimum accepted high time at `raw` is `DEBOUNCE_CYCLES`+1 cycles. Any shorter glitch produces no pulse and no level change.
- Pulse width is exactly 1 `clk` cycle, so the downstream FSM sees H or B for a single edge.

## Structure
- Shared package `alarm_pkg`:
  - `typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} deb_state_t`
  - the alarm FSM state encodings, so that both stages share one definition
- Sub-module `debounce_channel`:
  - contents: synchronizer, FSM, counter, level and pulse registers
  - parameterized by `DEBOUNCE_CYCLES`
  - instantiated twice in `input_conditioner`, once for H and once for B

## Test plan (bench uses `DEBOUNCE_CYCLES`=4)
- **Reset:** `rst`=1 for 3 cycles with `raw_h`=`raw_b`=1 → all outputs 0 during reset. After release, `h_pulse` and `b_pulse` each assert for exactly 1 cycle, 7 edges later.
- **Clean press:** `raw_h` 0→1 and held → `h_level` rises after edge 7 and `h_pulse` is high for exactly that one cycle. `b_*` stay 0.
- **Bounce rejection:** `raw_b` toggles 1,0,1,0 (1-cycle each), then 0 for 20 cycles → `b_level` and `b_pulse` stay 0 throughout.
- **Release glitch:** `raw_h` held high (accepted), then low for 2 cycles, then high again → `h_level` stays 1 and no second `h_pulse` occurs.
- **Simultaneous press and release:** `raw_h` and `raw_b` rise on the same edge → both pulses occur in the same cycle. Both inputs then drop → both levels fall after edge 7, with no pulses on release.
- **Reset mid-count:** `raw_h`=1 for 5 cycles, `rst` pulsed 1 cycle, `raw_h` kept high → no pulse before reset. Exactly one `h_pulse` occurs 7 edges after reset release.
